// File: rtl/serial_add_sub_32.sv
// serial_add_sub_32: bit-serial adder/subtractor, one full-adder slice per clock with registered carry
module serial_add_sub_32 #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SnA,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic             V,
    output logic             BUSY,
    output logic             DONE
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] op_a, op_b, acc;
    logic [CW-1:0] count;
    logic carry, s, c, load, last;
    assign s    = op_a[0] ^ op_b[0] ^ carry;
    assign c    = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    assign load = START && state != RUN;
    assign last = state == RUN && count == CW'(WIDTH - 1);
    assign BUSY = state == RUN;
    assign DONE = state == FIN;
    always_comb begin
        state_nx = load ? RUN : last ? FIN : state == FIN ? IDLE : state;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end
    // subtraction is A + ~B + 1: invert B on load and seed the carry with SnA
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
            Y     <= '0;
            CO    <= 1'b0;
            V     <= 1'b0;
        end else if (load) begin
            op_a  <= A;
            op_b  <= B ^ {WIDTH{SnA}};
            carry <= SnA;
            count <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            acc   <= {s, acc[WIDTH-1:1]};
            carry <= c;
            count <= count + 1'b1;
            if (last) begin
                Y  <= {s, acc[WIDTH-1:1]};
                CO <= c;
                V  <= carry ^ c;
            end
        end
    end
endmodule
